instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: IDLE -> REQ -> HOLD loop with
// jump prediction from the held word and redirect/flush handling.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        flush_q, flush_d;

    logic [31:0] redir_aligned;
    logic [31:0] next_pc;
    logic        is_jump;
    logic        unused_target_bits;

    assign redir_aligned      = {redirect_target[31:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];
    assign is_jump            = (instr_q[31:26] == 6'b000010);
    assign next_pc            = is_jump ? {pc_out_q[31:28], instr_q[25:0], 2'b00}
                                        : pc_out_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC_ALIGNED;
            addr_q   <= 32'h0;
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            flush_q  <= flush_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        flush_d  = flush_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                pc_d    = redirect_valid ? redir_aligned : pc_q;
                addr_d  = redirect_valid ? redir_aligned : pc_q;
            end
            ST_REQ: begin
                // The bus address stays put until ack; only pc tracks redirects.
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    flush_d = 1'b1;
                end
                if (imem_ack) begin
                    if (flush_q || redirect_valid) begin
                        flush_d = 1'b0;
                        addr_d  = redirect_valid ? redir_aligned : pc_q;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = addr_q;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    addr_d  = redir_aligned;
                    state_d = ST_REQ;
                end else if (instr_ready) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;

endmodule
